mipi_frame_writer: RTL and testbench
====================================

// Module: mipi_frame_writer
// PURPOSE
//  Downstream consumer of the MIPI bridge parallel pixel bus (10-bit RAW, HS/VS). On a start
//  command, captures exactly one full frame, zero-extends each pixel to 16 bits and buffers it
//  in a FIFO. An Avalon-MM write master drains the FIFO into SDRAM at consecutive halfword
//  addresses. Sits between the MIPI pixel port and the SDRAM controller in the qsys fabric.
// PARAMETERS
//  FIFO_DEPTH  64       pixel FIFO entries; power of two, >=4
//  ADDR_W      32       Avalon byte-address width
//  CNT_W       24       pixel counter width
//  MAX_PIXELS  7990272  pixel cap per frame (3264x2448); pixels beyond the cap are discarded
// PORTS
//  clk              in   1        system clock = MIPI pixel clock; all inputs synchronous to it
//  reset            in   1        asynchronous, active-high
//  pix_d            in   10       RAW pixel data
//  pix_hs           in   1        line valid, active high
//  pix_vs           in   1        frame valid, active high
//  start            in   1        1-cycle pulse: arm capture (ignored while busy=1)
//  base_addr        in   ADDR_W   SDRAM byte address of first pixel; sampled on accepted start
//  busy             out  1        high from accepted start until done pulse
//  done             out  1        1-cycle pulse when the last pixel is written to SDRAM
//  overflow         out  1        sticky: pixel dropped on full FIFO; cleared on accepted start
//  pixel_count      out  CNT_W    pixels accepted into FIFO this frame
//  avm_address      out  ADDR_W   write address
//  avm_write        out  1        write request
//  avm_writedata    out  16       {6'b0, pixel}
//  avm_byteenable   out  2        always 2'b11
//  avm_waitrequest  in   1        slave stall
// BEHAVIOUR
//  Reset values: busy=0 done=0 overflow=0 pixel_count=0 avm_write=0 avm_address=0
//   avm_writedata=0; FIFO empty; FSM=IDLE. Reset mid-frame aborts immediately, no done pulse.
//  FSM: IDLE -start-> SYNC (latch base_addr, clear count/overflow/FIFO)
//   SYNC: wait for pix_vs=0 (mid-frame start never captures a partial frame)
//   ARMED: pix_vs 0->1 -> CAPTURE
//   CAPTURE: pixel valid = pix_vs & pix_hs; push when count<MAX_PIXELS and FIFO not full;
//    valid pixel on full FIFO -> dropped, overflow<=1, count unchanged; pix_vs 1->0 -> DRAIN
//   DRAIN: FIFO empty and no write pending -> DONE
//   DONE: done=1 for one cycle, busy<=0 -> IDLE
//  Latency: pixel sampled cycle N is in FIFO at N+1; avm_write may assert no earlier than N+2.
//  Avalon: avm_write/address/writedata held stable while avm_waitrequest=1; a write completes
//   on a cycle with avm_write=1 & avm_waitrequest=0; next word may issue on the following cycle
//   (back-to-back, 1 word/clk sustained). Address of k-th pixel = base_addr + 2*k, mod 2^ADDR_W.
//  Simultaneous push and pop on a full FIFO: pop frees the slot; push accepted, no overflow.
//  start in the same cycle as done: ignored (busy still 1).
//  pixel_count saturates at MAX_PIXELS; wraps never.
// CONFIGURATION
//  MIPI_FRAME_WRITER_TEST_PATTERN_EN defined: pix_d replaced by a 10-bit counter that resets to
//   0 on every pix_vs rising edge and increments per valid pixel (wraps 1023->0); timing still
//   from pix_hs/pix_vs. Undefined: pix_d passes through unmodified.
// TESTING
//  4x4 frame, base=0x1000, no stall -> 16 writes at 0x1000..0x101E, data=pixels, done once, count=16
//  start with pix_vs already high -> current frame skipped; next 4x4 frame captured, 16 writes
//  waitrequest held 1 for 200 cycles, 8x16 frame, FIFO_DEPTH=64 -> overflow=1, count=64, 64 writes
//  start pulse while busy -> base_addr unchanged, no restart; one done pulse only
//  reset asserted after 5 pixels -> all outputs to reset values next edge, no done, avm_write=0
//  MAX_PIXELS=10, 4x4 frame -> exactly 10 writes, count=10, overflow=0; TEST_PATTERN_EN -> data 0..9

Source files
------------

// File: rtl/mipi_frame_writer.sv
// mipi_frame_writer
//   Captures one full frame from the 10-bit RAW parallel pixel bus after a start
//   command, buffers the pixels in a FIFO and drains them into SDRAM through an
//   Avalon-MM write master at consecutive halfword addresses.
//
// Ports
//   clk, reset             system clock / asynchronous active-high reset
//   pix_d, pix_hs, pix_vs  pixel bus (data, line valid, frame valid)
//   start, base_addr       arm capture; base byte address sampled on accepted start
//   busy, done, overflow   status (done is a 1-cycle pulse, overflow is sticky)
//   pixel_count            pixels accepted into the FIFO this frame
//   avm_*                  Avalon-MM write master
//
// Build option
//   MIPI_FRAME_WRITER_TEST_PATTERN_EN: replace pix_d by a per-frame pixel counter.
//
// state   | meaning
// IDLE    | waiting for start
// SYNC    | armed mid-frame, waiting for pix_vs low
// ARMED   | waiting for pix_vs rising edge
// CAPTURE | pushing valid pixels into the FIFO
// DRAIN   | frame ended, emptying FIFO to SDRAM
// DONE    | done pulse, returns to IDLE
module mipi_frame_writer #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 24,
  parameter int MAX_PIXELS = 7990272
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pix_d,
  input  logic              pix_hs,
  input  logic              pix_vs,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  pixel_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_ARMED, S_CAPTURE, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q;
  logic                vs_q;
  logic [9:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         fifo_cnt_q;
  logic [ADDR_W-1:0]   next_addr_q;
  logic [CNT_W-1:0]    count_q;
  logic                overflow_q, busy_q, done_q;
  logic                avm_write_q;
  logic [ADDR_W-1:0]   avm_address_q;
  logic [15:0]         avm_writedata_q;

  logic                vs_rise, cap_en, pix_valid, below_cap, wr_done;
  logic                full, push, drop, pop;
  logic [AW:0]         occ;
  logic [9:0]          pix_val;

  assign vs_rise   = pix_vs & ~vs_q;
  // The rising-edge cycle itself may carry a valid pixel, so ARMED captures it too.
  assign cap_en    = (state_q == S_CAPTURE) | ((state_q == S_ARMED) & vs_rise);
  assign pix_valid = cap_en & pix_vs & pix_hs;
  assign below_cap = count_q < CNT_W'(MAX_PIXELS);
  assign wr_done   = avm_write_q & ~avm_waitrequest;
  // Occupancy includes the word held in the Avalon output register, so at most
  // FIFO_DEPTH pixels are in flight at once.
  assign occ       = fifo_cnt_q + {{AW{1'b0}}, avm_write_q};
  assign full      = (occ == (AW+1)'(FIFO_DEPTH));
  assign push      = pix_valid & below_cap & (~full | wr_done);
  assign drop      = pix_valid & below_cap & full & ~wr_done;
  assign pop       = (fifo_cnt_q != '0) & (~avm_write_q | ~avm_waitrequest);

`ifdef MIPI_FRAME_WRITER_TEST_PATTERN_EN
  logic [9:0] pat_q, pat_cur;
  assign pat_cur = vs_rise ? 10'd0 : pat_q;
  assign pix_val = pat_cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pat_q <= '0;
    else       pat_q <= pat_cur + 10'(pix_vs & pix_hs);
  end
`else
  assign pix_val = pix_d;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pix_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      vs_q            <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
      next_addr_q     <= '0;
      count_q         <= '0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
    end else begin
      vs_q   <= pix_vs;
      done_q <= 1'b0;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        count_q  <= count_q + CNT_W'(1);
      end
      if (drop) overflow_q <= 1'b1;

      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      if (pop) begin
        rd_ptr_q        <= rd_ptr_q + AW'(1);
        avm_write_q     <= 1'b1;
        avm_address_q   <= next_addr_q;
        avm_writedata_q <= {6'b0, mem[rd_ptr_q]};
        next_addr_q     <= next_addr_q + ADDR_W'(2);
      end else if (wr_done) begin
        avm_write_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            next_addr_q <= base_addr;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_SYNC;
          end
        end
        S_SYNC:    if (!pix_vs) state_q <= S_ARMED;
        S_ARMED:   if (vs_rise) state_q <= S_CAPTURE;
        S_CAPTURE: if (!pix_vs) state_q <= S_DRAIN;
        S_DRAIN: begin
          if ((fifo_cnt_q == '0) && !avm_write_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign pixel_count    = count_q;
  assign avm_address    = avm_address_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = 2'b11;

endmodule

// File: tb/tb_mipi_frame_writer.sv
module tb_mipi_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_d;
  logic        pix_hs, pix_vs, start, start_m;
  logic [31:0] base_addr;
  logic        waitreq;
  logic        waitreq_m;

  logic        busy, done, overflow, avm_write;
  logic [23:0] pixel_count;
  logic [31:0] avm_address;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;

  logic        m_busy, m_done, m_overflow, m_write;
  logic [23:0] m_count;
  logic [31:0] m_address;
  logic [15:0] m_writedata;
  logic [1:0]  m_byteenable;

  mipi_frame_writer dut (
    .clk(clk), .reset(reset), .pix_d(pix_d), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .start(start), .base_addr(base_addr), .busy(busy), .done(done),
    .overflow(overflow), .pixel_count(pixel_count), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(waitreq)
  );

  mipi_frame_writer #(.MAX_PIXELS(10)) dut_m (
    .clk(clk), .reset(reset), .pix_d(pix_d), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .start(start_m), .base_addr(base_addr), .busy(m_busy), .done(m_done),
    .overflow(m_overflow), .pixel_count(m_count), .avm_address(m_address),
    .avm_write(m_write), .avm_writedata(m_writedata),
    .avm_byteenable(m_byteenable), .avm_waitrequest(waitreq_m)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: which pixels are written, where, and with what data.
  typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;
  wr_t         exp_q[$];
  bit          model_busy, model_armed, model_cap;
  logic [31:0] model_base;
  int          nacc, cap_limit;
  logic [9:0]  frame_vals[$];

  int          done_cnt, wr_cnt, m_done_cnt;
  logic [31:0] first_addr, last_addr, m_last_addr;
  logic [15:0] m_data[$];
  int          stall_left;
  bit          stall_rand;

  bit          prev_hold;
  logic [31:0] prev_addr;
  logic [15:0] prev_data;

  // Single compare process: every completed write against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_write", avm_write, 1'b1);
        check("hold_addr", avm_address, prev_addr);
        check("hold_data", avm_writedata, prev_data);
      end
      if (avm_write) check("byteenable", avm_byteenable, 2'b11);
      if (avm_write && !waitreq) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr 0x%0h, expected no write", avm_address);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", avm_address, e.addr);
          check("wr_data", avm_writedata, e.data);
        end
        if (wr_cnt == 0) first_addr = avm_address;
        last_addr = avm_address;
        wr_cnt++;
      end
      prev_hold = avm_write && waitreq;
      prev_addr = avm_address;
      prev_data = avm_writedata;
      if (done) begin
        check("done_after_drain", exp_q.size(), 0);
        done_cnt++;
        model_busy = 1'b0;
      end
      if (m_write) begin
        m_data.push_back(m_writedata);
        m_last_addr = m_address;
      end
      if (m_done) m_done_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        waitreq = 1'b1;
        stall_left--;
      end else begin
        waitreq = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_count"}, pixel_count, 0);
    check({tag, "_write"}, avm_write, 0);
    check({tag, "_addr"}, avm_address, 0);
    check({tag, "_data"}, avm_writedata, 0);
  endtask

  task automatic do_start(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    if (!model_busy) begin
      model_busy  = 1'b1;
      model_armed = 1'b1;
      model_base  = base;
      wr_cnt      = 0;
      done_cnt    = 0;
    end
    tick();
    start = 1'b0;
  endtask

  // One frame: w pixels per line, h lines, 2 blank cycles between lines.
  task automatic send_frame(input int w, input int h, input int reset_after,
                            input int start_line, input logic [31:0] start_base);
    int vidx;
    logic [9:0] val;
    wr_t e;
    pix_vs = 1'b0; pix_hs = 1'b0;
    repeat (3) tick();
    pix_vs = 1'b1;
    model_cap = model_armed;
    model_armed = 1'b0;
    nacc = 0;
    vidx = 0;
    frame_vals.delete();
    repeat (2) tick();
    for (int ln = 0; ln < h; ln++) begin
      if (ln == start_line) do_start(start_base);
      for (int px = 0; px < w; px++) begin
        pix_hs = 1'b1;
        pix_d  = 10'($urandom);
`ifdef MIPI_FRAME_WRITER_TEST_PATTERN_EN
        val = 10'(vidx);
`else
        val = pix_d;
`endif
        frame_vals.push_back(val);
        if (model_cap && nacc < cap_limit) begin
          e.addr = model_base + 32'(2 * nacc);
          e.data = {6'b0, val};
          exp_q.push_back(e);
          nacc++;
        end
        vidx++;
        tick();
        if (vidx == reset_after) begin
          reset = 1'b1;
          #1;
          check_reset_vals("rst_async");
          exp_q.delete();
          model_busy = 1'b0; model_cap = 1'b0; model_armed = 1'b0;
          tick();
          check_reset_vals("rst_edge");
          reset = 1'b0;
        end
      end
      pix_hs = 1'b0;
      repeat (2) tick();
    end
    pix_vs = 1'b0;
    model_cap = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget, input bit start_on_done);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    if (seen && start_on_done) begin
      base_addr = 32'hDEAD_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_on_done_ignored", busy, 0);
      repeat (3) tick();
      check("start_on_done_idle", busy, 0);
    end
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, h;
    logic [31:0] b;
    reset = 1'b1; pix_d = '0; pix_hs = 0; pix_vs = 0; start = 0; start_m = 0;
    base_addr = '0; waitreq_m = 1'b0; stall_left = 0; stall_rand = 0;
    cap_limit = 1 << 30;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // 4x4 frame, no stall, literal addresses.
    do_start(32'h1000);
    check("busy_after_start", busy, 1);
    send_frame(4, 4, -1, -1, 0);
    wait_done(300, 0);
    check("t1_writes", wr_cnt, 16);
    check("t1_first", first_addr, 32'h1000);
    check("t1_last", last_addr, 32'h101E);
    check("t1_done", done_cnt, 1);
    check("t1_count", pixel_count, 16);
    check("t1_overflow", overflow, 0);
    check("t1_busy", busy, 0);

    // Start while a frame is already running: that frame is skipped.
    send_frame(4, 4, -1, 1, 32'h4000);
    send_frame(4, 4, -1, -1, 0);
    wait_done(300, 0);
    check("t2_writes", wr_cnt, 16);
    check("t2_first", first_addr, 32'h4000);
    check("t2_done", done_cnt, 1);

    // Start pulse while busy is ignored; start on the done cycle is ignored.
    do_start(32'h2000);
    send_frame(4, 4, -1, 2, 32'h8000);
    check("t3_busy_mid", busy, 1);
    wait_done(300, 1);
    check("t3_writes", wr_cnt, 16);
    check("t3_first", first_addr, 32'h2000);
    check("t3_last", last_addr, 32'h201E);
    check("t3_done", done_cnt, 1);

    // Long stall: 128-pixel frame into a 64-deep path.
    stall_left = 200;
    cap_limit = 64;
    do_start(32'h0010_0000);
    send_frame(16, 8, -1, -1, 0);
    check("t4_overflow", overflow, 1);
    check("t4_count", pixel_count, 64);
    wait_done(800, 0);
    check("t4_writes", wr_cnt, 64);
    check("t4_last", last_addr, 32'h0010_007E);
    check("t4_done", done_cnt, 1);
    cap_limit = 1 << 30;

    // Randomized frames with random stalls.
    stall_rand = 1'b1;
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 7);
      b = $urandom & 32'hFFFF_FFFE;
      if (it == 0) b = 32'hFFFF_FFF8;
      do_start(b);
      check("rnd_overflow_cleared", overflow, 0);
      send_frame(w, h, -1, -1, 0);
      wait_done(3000, 0);
      check("rnd_writes", wr_cnt, w * h);
      check("rnd_count", pixel_count, w * h);
      check("rnd_done", done_cnt, 1);
      check("rnd_overflow", overflow, 0);
    end
    stall_rand = 1'b0;

    // Pixel cap of 10 on the second instance.
    m_data.delete();
    m_done_cnt = 0;
    base_addr = 32'h0;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    send_frame(4, 4, -1, -1, 0);
    for (int i = 0; i < 100 && m_done_cnt == 0; i++) tick();
    tick();
    check("cap_writes", m_data.size(), 10);
    for (int i = 0; i < 10 && i < m_data.size(); i++)
      check("cap_data", m_data[i], {6'b0, frame_vals[i]});
`ifdef MIPI_FRAME_WRITER_TEST_PATTERN_EN
    if (m_data.size() > 9) check("cap_pattern_last", m_data[9], 16'd9);
`endif
    check("cap_last_addr", m_last_addr, 32'h12);
    check("cap_count", m_count, 10);
    check("cap_overflow", m_overflow, 0);
    check("cap_done", m_done_cnt, 1);

    // Reset after 5 pixels: no done, everything back to reset values.
    do_start(32'h3000);
    send_frame(4, 4, 5, -1, 0);
    repeat (20) tick();
    check("rst_no_done", done_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_write", avm_write, 0);
    check("rst_count", pixel_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
